// File: rtl/tt_sweep_seq.sv
// tt_sweep_seq: exhaustive stimulus sequencer for small combinational gates.
//
// The sequencer walks every N_IN-bit input vector in ascending binary order.
// It holds each vector for DWELL cycles and samples the gate output y on the
// last cycle of each vector. The all-ones vector is the last one, and the
// sequence never wraps.
//
// Optional checker: compile with TT_SWEEP_SEQ_CHECK_EN defined. The checker
// compares y against the OR-reduction of vec on every sample cycle and counts
// the mismatches in a saturating counter. When the macro is not defined, y is
// unused, err_cnt is held at zero and pass follows done.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (taken in IDLE or DONE, ignored while busy)
//   pause      freeze the sweep: vector held, dwell count frozen, no sample
//   vec        current stimulus vector, MSB = first gate input
//   vec_valid  vec is a live sweep vector
//   busy       sweep in progress
//   done       sweep finished; level, held until the next start
//   y          gate output under test
//   err_cnt    saturating mismatch count
//   pass       done with no mismatches
module tt_sweep_seq #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned DWELL = 1,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pause,
  output logic [N_IN-1:0]  vec,
  output logic             vec_valid,
  output logic             busy,
  output logic             done,
  input  logic             y,
  output logic [ERR_W-1:0] err_cnt,
  output logic             pass
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [N_IN-1:0] vec_nxt;
  logic [CW-1:0]   dwell_cnt, dwell_nxt;
  logic            vec_valid_nxt, busy_nxt, done_nxt;
  logic            sample;     // final, unpaused cycle of the current vector
  logic            clear_err;  // a new sweep is being launched

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      vec       <= '0;
      dwell_cnt <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      dwell_cnt <= dwell_nxt;
      vec_valid <= vec_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    vec_nxt       = vec;
    dwell_nxt     = dwell_cnt;
    vec_valid_nxt = vec_valid;
    busy_nxt      = busy;
    done_nxt      = done;
    sample        = 1'b0;
    clear_err     = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt     = S_DRIVE;
          vec_nxt       = '0;
          dwell_nxt     = '0;
          vec_valid_nxt = 1'b1;
          busy_nxt      = 1'b1;
          done_nxt      = 1'b0;
          clear_err     = 1'b1;
        end
      end

      S_DRIVE: begin
        // pause outranks everything, including the last-cycle step
        if (!pause) begin
          if (dwell_cnt == DWELL_LAST) begin
            sample    = 1'b1;
            dwell_nxt = '0;
            if (&vec) begin
              state_nxt     = S_DONE;
              vec_nxt       = '0;
              vec_valid_nxt = 1'b0;
              busy_nxt      = 1'b0;
              done_nxt      = 1'b1;
            end else begin
              vec_nxt = vec + 1'b1;
            end
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_nxt     = S_IDLE;
        vec_nxt       = '0;
        dwell_nxt     = '0;
        vec_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
      end
    endcase
  end

`ifdef TT_SWEEP_SEQ_CHECK_EN
  logic expected;
  logic mismatch;

  assign expected = |vec;
  assign mismatch = sample && (y != expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clear_err) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign pass = done && (err_cnt == '0);
`else
  logic unused_ok;

  assign unused_ok = ^{y, sample, clear_err};
  assign err_cnt   = '0;
  assign pass      = done;
`endif

endmodule

// File: tb/tb_tt_sweep_seq.sv
// Testbench for tt_sweep_seq. Three instances with N_IN=3 are used:
//   index 0: DWELL=1, ERR_W=4
//   index 1: DWELL=3, ERR_W=4
//   index 2: DWELL=2, ERR_W=2
// When a sweep starts, the bench pushes the expected vector sequence into a
// queue. It pops one entry for each unpaused DUT cycle. The bench counts the
// expected mismatches from the y values it drives itself.
module tb_tt_sweep_seq;

`ifdef TT_SWEEP_SEQ_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i [3];
  logic       pause_i [3];
  logic       y_i     [3];
  logic [2:0] vec_o   [3];
  logic       valid_o [3];
  logic       busy_o  [3];
  logic       done_o  [3];
  logic       pass_o  [3];
  logic [3:0] err0, err1;
  logic [1:0] err2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tt_sweep_seq #(.N_IN(3), .DWELL(1), .ERR_W(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_i[0]), .pause(pause_i[0]),
    .vec(vec_o[0]), .vec_valid(valid_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .y(y_i[0]), .err_cnt(err0), .pass(pass_o[0])
  );

  tt_sweep_seq #(.N_IN(3), .DWELL(3), .ERR_W(4)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start_i[1]), .pause(pause_i[1]),
    .vec(vec_o[1]), .vec_valid(valid_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .y(y_i[1]), .err_cnt(err1), .pass(pass_o[1])
  );

  tt_sweep_seq #(.N_IN(3), .DWELL(2), .ERR_W(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start_i[2]), .pause(pause_i[2]),
    .vec(vec_o[2]), .vec_valid(valid_o[2]), .busy(busy_o[2]), .done(done_o[2]),
    .y(y_i[2]), .err_cnt(err2), .pass(pass_o[2])
  );

  function automatic int dwell_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  function automatic int errmax_of(input int k);
    return (k == 2) ? 3 : 15;
  endfunction

  function automatic logic [3:0] err_of(input int k);
    case (k)
      0:       return err0;
      1:       return err1;
      default: return {2'b00, err2};
    endcase
  endfunction

  // Runs one sweep on instance k. The task starts at a negedge and ends at
  // the negedge where DONE is visible.
  // ymode: 0 correct OR3, 1 stuck-0, 2 stuck-1, 3 correct only on the final
  //        dwell cycle of each vector (inverted on the other cycles).
  // pause_vec/pause_len: hold pause for pause_len edges the first time
  //        pause_vec is shown. If pause_vec is 0, pause is raised with start.
  // start_at: raise start for one edge on this DRIVE cycle (0 = never).
  task automatic run_sweep(input int k, input int ymode, input int pause_vec,
                           input int pause_len, input int start_at);
    logic [2:0] q[$];
    logic [2:0] cur;
    logic [3:0] exp_err;
    logic       yv;
    int         mm, cyc, pause_left;
    bit         paused_once, hold, fin;
    for (int v = 0; v < 8; v++)
      for (int d = 0; d < dwell_of(k); d++) q.push_back(3'(v));
    start_i[k] = 1'b1;
    pause_i[k] = (pause_len > 0 && pause_vec == 0);
    @(negedge clk);
    start_i[k]  = 1'b0;
    mm          = 0;
    cyc         = 0;
    pause_left  = 0;
    paused_once = 1'b0;
    while (q.size() > 0) begin
      cur     = q[0];
      exp_err = CHECK ? 4'((mm > errmax_of(k)) ? errmax_of(k) : mm) : 4'd0;
      n_chk++;
      if (vec_o[k] !== cur || valid_o[k] !== 1'b1 || busy_o[k] !== 1'b1 ||
          done_o[k] !== 1'b0 || err_of(k) !== exp_err || pass_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL drive_cycle inst%0d cyc%0d: got vec=%0d valid=%b busy=%b done=%b err=%0d pass=%b, want vec=%0d valid=1 busy=1 done=0 err=%0d pass=0",
                 k, cyc, vec_o[k], valid_o[k], busy_o[k], done_o[k], err_of(k), pass_o[k], cur, exp_err);
      end
      cyc++;
      start_i[k] = (cyc == start_at);
      if (!paused_once && pause_len > 0 && cur == 3'(pause_vec)) begin
        paused_once = 1'b1;
        pause_left  = pause_len;
      end
      hold = (pause_left > 0);
      if (hold) pause_left--;
      pause_i[k] = hold;
      fin = (q.size() == 1) || (q[1] != cur);
      case (ymode)
        0:       yv = |cur;
        1:       yv = 1'b0;
        2:       yv = 1'b1;
        default: yv = fin ? |cur : ~|cur;
      endcase
      // a wrong y while paused counts only if the DUT samples during pause
      if (hold && ymode == 0) yv = ~|cur;
      y_i[k] = yv;
      if (!hold) begin
        if (fin && (yv != |cur)) mm++;
        void'(q.pop_front());
      end
      @(negedge clk);
    end
    start_i[k] = 1'b0;
    pause_i[k] = 1'b0;
    y_i[k]     = 1'b0;
    exp_err = CHECK ? 4'((mm > errmax_of(k)) ? errmax_of(k) : mm) : 4'd0;
    n_chk++;
    if (vec_o[k] !== 3'd0 || valid_o[k] !== 1'b0 || busy_o[k] !== 1'b0 ||
        done_o[k] !== 1'b1 || err_of(k) !== exp_err || pass_o[k] !== (exp_err == 4'd0)) begin
      n_fail++;
      $display("FAIL done_state inst%0d: got vec=%0d valid=%b busy=%b done=%b err=%0d pass=%b, want vec=0 valid=0 busy=0 done=1 err=%0d pass=%b",
               k, vec_o[k], valid_o[k], busy_o[k], done_o[k], err_of(k), pass_o[k], exp_err, (exp_err == 4'd0));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_i[k] = 1'b0;
      pause_i[k] = 1'b0;
      y_i[k]     = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (vec_o[k] !== 3'd0 || valid_o[k] !== 1'b0 || busy_o[k] !== 1'b0 ||
          done_o[k] !== 1'b0 || err_of(k) !== 4'd0 || pass_o[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state inst%0d: got vec=%0d valid=%b busy=%b done=%b err=%0d pass=%b, want all zero",
                 k, vec_o[k], valid_o[k], busy_o[k], done_o[k], err_of(k), pass_o[k]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b done=%b, want busy=0 done=0", busy_o[0], done_o[0]);
    end
  endtask

  task automatic test_sweep_dwell1();
    run_sweep(0, 0, 0, 0, 0);
  endtask

  task automatic test_sweep_dwell3();
    run_sweep(1, 3, 0, 0, 0);
  endtask

  task automatic test_pause();
    run_sweep(2, 0, 3, 4, 0);
    run_sweep(1, 0, 0, 2, 0);
  endtask

  task automatic test_errors();
    run_sweep(0, 1, 0, 0, 0);
    run_sweep(2, 2, 0, 0, 0);
    run_sweep(2, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_sweep(0, 1, 0, 0, 0);
    run_sweep(0, 0, 0, 0, 4);
    run_sweep(1, 0, 0, 0, 7);
  endtask

  task automatic test_reset_mid();
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (vec_o[0] !== 3'd5 || valid_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_vec: got vec=%0d valid=%b, want vec=5 valid=1", vec_o[0], valid_o[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (vec_o[0] !== 3'd0 || valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 ||
        done_o[0] !== 1'b0 || err_of(0) !== 4'd0 || pass_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got vec=%0d valid=%b busy=%b done=%b err=%0d pass=%b, want all zero",
               vec_o[0], valid_o[0], busy_o[0], done_o[0], err_of(0), pass_o[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if (vec_o[0] !== 3'd0 || valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || done_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL no_resume: got vec=%0d valid=%b busy=%b done=%b, want idle zeros",
               vec_o[0], valid_o[0], busy_o[0], done_o[0]);
    end
    run_sweep(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_sweep_dwell1();
    test_sweep_dwell3();
    test_pause();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule
